// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin front end that time-shares one external
// combinational 6x6 unsigned multiplier between NREQ requesters.
//   Request side : req_valid/req_ready per requester, operands packed 6 bits each
//   Multiplier   : mul_a/mul_b registered operands out, mul_p product in
//   Response side: rsp_valid/rsp_ready with rsp_id (winner index) and rsp_p
//   Status       : busy (any stage occupied), ops_done (consumed responses)
// Latency: accept at edge N, response valid after edge N+1; one op/cycle.
// Backpressure: a stalled response holds S2, then S1; req_ready drops when both are full.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*6-1:0]   req_a,
  input  logic [NREQ*6-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [5:0]          mul_a,
  output logic [5:0]          mul_b,
  input  logic [11:0]         mul_p,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [11:0]         rsp_p,
  output logic                busy,
  output logic [CNTW-1:0]     ops_done
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

  // S1: operands currently presented to the multiplier
  logic            v1_q, v1_d;
  logic [IDW-1:0]  id1_q, id1_d;
  logic [5:0]      mul_a_q, mul_a_d;
  logic [5:0]      mul_b_q, mul_b_d;
  // S2: captured product awaiting the consumer
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [11:0]     rsp_p_q, rsp_p_d;
  // Arbitration pointer and completion counter
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] ops_q, ops_d;

  logic            adv1, adv2, accept;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;
  logic [5:0]      a_arr [NREQ];
  logic [5:0]      b_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[6*i +: 6];
      b_arr[i] = req_b[6*i +: 6];
    end
  end

  // Rotating-priority search. Walking from the far end back toward ptr
  // lets the candidate closest to ptr overwrite any later one.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req_valid[cand[IDW-1:0]]) grant_idx = cand[IDW-1:0];
    end
  end

  always_comb begin
    adv2   = !rsp_valid_q || rsp_ready;
    adv1   = !v1_q || adv2;
    // Gating with rst keeps req_ready low during the reset cycle, so no
    // requester believes it was accepted by a pipeline that is being cleared.
    accept = adv1 && (|req_valid) && !rst;

    req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    v1_d        = v1_q;
    id1_d       = id1_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    ptr_d       = ptr_q;
    ops_d       = ops_q;

    if (adv2) begin
      rsp_valid_d = v1_q;
      if (v1_q) begin
        rsp_id_d = id1_q;
        rsp_p_d  = mul_p;
      end
    end

    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        id1_d   = grant_idx;
        mul_a_d = a_arr[grant_idx];
        mul_b_d = b_arr[grant_idx];
      end
    end

    if (accept) begin
      ptr_d = (grant_idx == LAST) ? '0 : grant_idx + IDW'(1);
    end

    if (rsp_valid_q && rsp_ready) begin
      ops_d = ops_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      id1_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      ptr_q       <= '0;
      ops_q       <= '0;
    end else begin
      v1_q        <= v1_d;
      id1_q       <= id1_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      ptr_q       <= ptr_d;
      ops_q       <= ops_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = v1_q | rsp_valid_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter (NREQ=4, CNTW=4 so the counter wraps quickly).
// Drives inputs 1 time unit after each rising edge and samples outputs there.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic [3:0]  req_ready;
  logic [5:0]  mul_a;
  logic [5:0]  mul_b;
  logic [11:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [11:0] rsp_p;
  logic        busy;
  logic [3:0]  ops_done;

  int n_chk  = 0;
  int n_fail = 0;
  int gseq [6] = '{0, 1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  // Stand-in for the shared combinational multiplier.
  assign mul_p = 12'(mul_a) * 12'(mul_b);

  mult_share_arbiter #(.NREQ(4), .CNTW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[6*i +: 6] = 6'(a);
    req_b[6*i +: 6] = 6'(b);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();

    // ---- reset cycle: no grants even with every requester asking
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    tick();
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ops_done", int'(ops_done), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    chk("rst_mul_b", int'(mul_b), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_p", int'(rsp_p), 0);
    rst       = 1'b0;
    req_valid = '0;

    // ---- fairness: everyone valid, A=i+1, B=7
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 7);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      if (c < 6) chk("fair_grant", int'(req_ready), 1 << gseq[c]);
      chk("fair_rsp_valid", int'(rsp_valid), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("fair_rsp_id", int'(rsp_id), gseq[c-2]);
        chk("fair_rsp_p", int'(rsp_p), 7 * (gseq[c-2] + 1));
      end
      chk("fair_ops", int'(ops_done), (c >= 2) ? c - 2 : 0);
      tick();
    end
    chk("fair_end_ops", int'(ops_done), 6);
    chk("fair_end_busy", int'(busy), 0);

    // ---- single request 63x63 from requester 0 (ptr is at 2)
    set_op(0, 63, 63);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", int'(req_ready), 1);
    tick();
    req_valid = '0;
    #1;
    chk("single_ready_drop", int'(req_ready), 0);
    chk("single_mul_a", int'(mul_a), 63);
    chk("single_mul_b", int'(mul_b), 63);
    chk("single_busy", int'(busy), 1);
    chk("single_rsp_early", int'(rsp_valid), 0);
    tick();
    chk("single_rsp_valid", int'(rsp_valid), 1);
    chk("single_rsp_id", int'(rsp_id), 0);
    chk("single_rsp_p", int'(rsp_p), 3969);
    chk("single_ops_pre", int'(ops_done), 6);
    tick();
    chk("single_rsp_gone", int'(rsp_valid), 0);
    chk("single_ops", int'(ops_done), 7);
    chk("single_idle", int'(busy), 0);

    // ---- backpressure: 5x7 from id1, 9x9 from id2 with consumer stalled (ptr is at 1)
    rsp_ready = 1'b0;
    set_op(1, 5, 7);
    set_op(2, 9, 9);
    req_valid = 4'b0110;
    #1;
    chk("bp_grant1", int'(req_ready), 2);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("bp_grant2", int'(req_ready), 4);
    tick();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0001;
      #1;
      chk("bp_full_ready", int'(req_ready), 0);
      chk("bp_rsp_valid", int'(rsp_valid), 1);
      chk("bp_rsp_id", int'(rsp_id), 1);
      chk("bp_rsp_p", int'(rsp_p), 35);
      chk("bp_busy", int'(busy), 1);
      chk("bp_ops", int'(ops_done), 7);
      tick();
    end

    // ---- drain and accept in the same cycle
    rsp_ready = 1'b1;
    set_op(3, 2, 3);
    req_valid = 4'b1000;
    #1;
    chk("drain_accept", int'(req_ready), 8);
    tick();
    req_valid = '0;
    #1;
    chk("drain_rsp_id", int'(rsp_id), 2);
    chk("drain_rsp_p", int'(rsp_p), 81);
    chk("drain_ops", int'(ops_done), 8);
    chk("drain_mul_a", int'(mul_a), 2);
    chk("drain_mul_b", int'(mul_b), 3);
    tick();
    chk("drain_rsp3_valid", int'(rsp_valid), 1);
    chk("drain_rsp3_id", int'(rsp_id), 3);
    chk("drain_rsp3_p", int'(rsp_p), 6);
    chk("drain_ops2", int'(ops_done), 9);
    tick();
    chk("drain_end_valid", int'(rsp_valid), 0);
    chk("drain_end_ops", int'(ops_done), 10);
    chk("drain_end_busy", int'(busy), 0);

    // ---- reset with two operations in flight (ptr wrapped to 0)
    rsp_ready = 1'b0;
    set_op(0, 1, 1);
    set_op(1, 2, 2);
    req_valid = 4'b0011;
    #1;
    chk("mid_grant0", int'(req_ready), 1);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("mid_grant1", int'(req_ready), 2);
    tick();
    chk("mid_full_valid", int'(rsp_valid), 1);
    chk("mid_full_busy", int'(busy), 1);
    rst       = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("mid_rst_ready", int'(req_ready), 0);
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    chk("mid_rsp_valid", int'(rsp_valid), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_ops", int'(ops_done), 0);
    chk("mid_mul_a", int'(mul_a), 0);
    set_op(2, 4, 5);
    req_valid = 4'b0100;
    #1;
    chk("post_rst_grant", int'(req_ready), 4);
    tick();
    req_valid = '0;
    #1;
    chk("post_rst_no_stale", int'(rsp_valid), 0);
    chk("post_rst_mul_a", int'(mul_a), 4);
    tick();
    chk("post_rst_rsp_valid", int'(rsp_valid), 1);
    chk("post_rst_rsp_id", int'(rsp_id), 2);
    chk("post_rst_rsp_p", int'(rsp_p), 20);
    chk("post_rst_ops0", int'(ops_done), 0);
    tick();
    chk("post_rst_ops1", int'(ops_done), 1);
    chk("post_rst_idle", int'(rsp_valid), 0);

    // ---- counter to 15 with back-to-back ops from id1, then 0x45 wraps it
    set_op(1, 3, 3);
    for (int c = 0; c < 14; c++) begin
      req_valid = 4'b0010;
      #1;
      chk("wrap_grant", int'(req_ready), 2);
      if (c >= 2) chk("wrap_rsp_p", int'(rsp_p), 9);
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    chk("wrap_ops15", int'(ops_done), 15);
    chk("wrap_idle", int'(rsp_valid), 0);
    set_op(0, 0, 45);
    req_valid = 4'b0001;
    #1;
    chk("zero_grant", int'(req_ready), 1);
    tick();
    req_valid = '0;
    tick();
    chk("zero_rsp_valid", int'(rsp_valid), 1);
    chk("zero_rsp_id", int'(rsp_id), 0);
    chk("zero_rsp_p", int'(rsp_p), 0);
    chk("zero_ops_pre", int'(ops_done), 15);
    tick();
    chk("wrap_ops0", int'(ops_done), 0);
    chk("wrap_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
